// File: rtl/conv_layer_sched.sv
// Layer sequencer above the conv controller: launches one conv pass per layer, hands each
// finished OFM buffer to writeback, flips the ping-pong select, and recovers via watchdog/abort.
module conv_layer_sched #(
    parameter int NUM_LAYERS = 4,
    parameter int TIMEOUT    = 4096
) (
    input  logic                          clk1,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [$clog2(NUM_LAYERS):0]   layer_cnt,
    input  logic                          end_conv,
    input  logic                          wb_ack,
    output logic                          start_conv,
    output logic                          wb_req,
    output logic [$clog2(NUM_LAYERS)-1:0] layer_idx,
    output logic                          swap_buf,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    err
);
    localparam int IDX_W = $clog2(NUM_LAYERS);
    localparam int CNT_W = IDX_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_LAYERS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
    // The pass expires on the edge the watchdog would step to TIMEOUT-1.
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 2);
    localparam logic [1:0]       ERR_NONE = 2'b00;
    localparam logic [1:0]       ERR_CFG  = 2'b01;
    localparam logic [1:0]       ERR_WDOG = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_CONV = 3'd2,
        S_WRITEBACK = 3'd3,
        S_NEXT      = 3'd4,
        S_DONE      = 3'd5,
        S_ERR       = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic             swap_q, swap_d;
    logic [1:0]       err_q, err_d;
    logic             cnt_legal_s;
    logic             last_layer_s;

    assign cnt_legal_s  = (layer_cnt != {CNT_W{1'b0}}) && (layer_cnt <= CNT_MAX);
    assign last_layer_s = ({1'b0, idx_q} == (cnt_q - CNT_ONE));

    // Next-state and next-register computation; abort outranks every transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdog_d  = wdog_q;
        swap_d  = swap_q;
        err_d   = err_q;
        if (abort) begin
            state_d = S_IDLE;
            idx_d   = {IDX_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && cnt_legal_s) begin
                        state_d = S_LAUNCH;
                        cnt_d   = layer_cnt;
                        idx_d   = {IDX_W{1'b0}};
                        err_d   = ERR_NONE;
                    end else if (start) begin
                        err_d   = ERR_CFG;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LAUNCH: begin
                    state_d = S_WAIT_CONV;
                    wdog_d  = {WD_W{1'b0}};
                end
                S_WAIT_CONV: begin
                    if (end_conv) begin
                        state_d = S_WRITEBACK;
                    end else if (wdog_q == WD_LAST) begin
                        state_d = S_ERR;
                        err_d   = ERR_WDOG;
                        wdog_d  = wdog_q + WD_ONE;
                    end else begin
                        wdog_d  = wdog_q + WD_ONE;
                    end
                end
                S_WRITEBACK: begin
                    if (wb_ack) begin
                        state_d = S_NEXT;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end
                S_NEXT: begin
                    swap_d = ~swap_q;
                    if (last_layer_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LAUNCH;
                        idx_d   = idx_q + IDX_ONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ERR:   state_d = S_ERR;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            wdog_q  <= {WD_W{1'b0}};
            swap_q  <= 1'b0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdog_q  <= wdog_d;
            swap_q  <= swap_d;
            err_q   <= err_d;
        end
    end

    assign start_conv = (state_q == S_LAUNCH);
    assign wb_req     = (state_q == S_WRITEBACK);
    assign done       = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign layer_idx  = idx_q;
    assign swap_buf   = swap_q;
    assign err        = err_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched: a timestamp-based model of the scheduling rules is
// compared against the DUT every cycle, alongside hand-computed expectations per scenario.
module tb_conv_layer_sched;
    localparam int NUM_LAYERS = 4;
    localparam int TIMEOUT    = 16;

    logic       clk1 = 1'b0;
    logic       rst, start, abort, end_conv, wb_ack;
    logic [2:0] layer_cnt;
    logic       start_conv, wb_req, swap_buf, busy, done;
    logic [1:0] layer_idx;
    logic [1:0] err;

    always #5 clk1 = ~clk1;

    conv_layer_sched #(.NUM_LAYERS(NUM_LAYERS), .TIMEOUT(TIMEOUT)) dut (
        .clk1(clk1), .rst(rst), .start(start), .abort(abort), .layer_cnt(layer_cnt),
        .end_conv(end_conv), .wb_ack(wb_ack), .start_conv(start_conv), .wb_req(wb_req),
        .layer_idx(layer_idx), .swap_buf(swap_buf), .busy(busy), .done(done), .err(err)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;
    int sc_count = 0;
    int done_count = 0;

    // Model: events are cycle timestamps (cycle n = the period after the n-th rising edge).
    bit   m_busy, m_wait, m_wb, m_swap;
    int   m_idx, m_cnt, m_launch, m_done, m_next;
    logic [1:0] m_err;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, n);
        end
    endtask

    task automatic model_update();
        bit was_busy, was_wb;
        n++;
        was_busy = m_busy;
        was_wb   = m_wb;
        if (rst) begin
            m_busy = 0; m_wait = 0; m_wb = 0; m_swap = 0; m_err = 2'b00;
            m_idx = 0; m_cnt = 0; m_launch = -10; m_done = -10; m_next = -10;
        end else if (abort) begin
            m_busy = 0; m_wait = 0; m_wb = 0; m_idx = 0;
            m_launch = -10; m_done = -10; m_next = -10;
        end else begin
            if (n == m_done + 1) m_busy = 0;
            // One cycle after the ack: toggle buffer, then next launch or done.
            if (n == m_next) begin
                m_swap = ~m_swap;
                if (m_idx == m_cnt - 1) m_done = n;
                else begin
                    m_idx++; m_launch = n; m_wait = 1;
                end
            end
            if (!was_busy && start) begin
                if (layer_cnt >= 1 && layer_cnt <= NUM_LAYERS) begin
                    m_busy = 1; m_idx = 0; m_cnt = layer_cnt; m_err = 2'b00;
                    m_launch = n; m_wait = 1;
                end else m_err = 2'b01;
            end
            // end_conv counts from the first edge after the launch cycle.
            if (m_wait && n >= m_launch + 2) begin
                if (end_conv) begin
                    m_wait = 0; m_wb = 1;
                end else if (n == m_launch + TIMEOUT) begin
                    m_wait = 0; m_err = 2'b10;
                end
            end
            if (was_wb && wb_ack) begin
                m_wb = 0; m_next = n + 1;
            end
        end
    endtask

    task automatic compare_all();
        check("start_conv", int'(start_conv), int'(n == m_launch));
        check("wb_req",     int'(wb_req),     int'(m_wb));
        check("done",       int'(done),       int'(n == m_done));
        check("busy",       int'(busy),       int'(m_busy));
        check("layer_idx",  int'(layer_idx),  m_idx);
        check("swap_buf",   int'(swap_buf),   int'(m_swap));
        check("err",        int'(err),        int'(m_err));
        if (start_conv) sc_count++;
        if (done) done_count++;
    endtask

    task automatic step();
        @(posedge clk1);
        model_update();
        @(negedge clk1);
        compare_all();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic pulse_start(input int cnt);
        start = 1'b1; layer_cnt = cnt[2:0]; step(); start = 1'b0;
    endtask

    task automatic pulse_end();
        end_conv = 1'b1; step(); end_conv = 1'b0;
    endtask

    task automatic pulse_ack();
        wb_ack = 1'b1; step(); wb_ack = 1'b0;
    endtask

    function automatic int sig(input int w);
        case (w)
            0:       return int'(start_conv);
            1:       return int'(wb_req);
            2:       return int'(done);
            default: return 0;
        endcase
    endfunction

    task automatic wait_sig(input int w, input string name);
        int k = 0;
        while (sig(w) == 0 && k < 100) begin
            step(); k++;
        end
        check(name, sig(w), 1);
    endtask

    task automatic do_layer(input int conv_dly, input int ack_dly, input int exp_idx);
        wait_sig(0, "start_conv seen");
        check("layer_idx at launch", int'(layer_idx), exp_idx);
        idle(conv_dly); pulse_end();
        wait_sig(1, "wb_req seen");
        idle(ack_dly); pulse_ack();
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; abort = 1'b0; end_conv = 1'b0; wb_ack = 1'b0;
        layer_cnt = 3'd1;
        idle(3);
        rst = 1'b0; start = 1'b0;
        idle(1);
        check("reset busy", int'(busy), 0);
        check("reset swap", int'(swap_buf), 0);
        check("reset err", int'(err), 0);
        check("reset idx", int'(layer_idx), 0);

        // T1: single layer
        sc_count = 0; done_count = 0;
        pulse_start(1);
        do_layer(10, 3, 0);
        step();
        check("T1 done 2 cycles after ack", int'(done), 1);
        check("T1 swap", int'(swap_buf), 1);
        idle(2);
        check("T1 start_conv pulses", sc_count, 1);
        check("T1 done pulses", done_count, 1);
        check("T1 busy after", int'(busy), 0);

        // T2: full four-layer run
        sc_count = 0; done_count = 0;
        pulse_start(4);
        for (int i = 0; i < 4; i++) do_layer(3 + i, 1 + i, i);
        wait_sig(2, "T2 done seen");
        idle(2);
        check("T2 start_conv pulses", sc_count, 4);
        check("T2 done pulses", done_count, 1);
        check("T2 swap after 4 toggles", int'(swap_buf), 1);

        // T3: illegal counts, then a legal start clears err
        sc_count = 0;
        pulse_start(0);
        check("T3 err cnt0", int'(err), 1);
        check("T3 busy cnt0", int'(busy), 0);
        idle(1);
        pulse_start(5);
        idle(2);
        check("T3 err cnt5", int'(err), 1);
        check("T3 no launch", sc_count, 0);
        pulse_start(1);
        check("T3 err cleared", int'(err), 0);
        do_layer(2, 0, 0);
        wait_sig(2, "T3 done seen");
        idle(1);

        // T4: watchdog expiry, then abort
        pulse_start(1);
        wait_sig(0, "T4 start_conv seen");
        idle(15);
        check("T4 err before expiry", int'(err), 0);
        step();
        check("T4 err at start_conv+16", int'(err), 2);
        idle(5);
        check("T4 ERR busy", int'(busy), 1);
        abort = 1'b1; step(); abort = 1'b0;
        check("T4 busy after abort", int'(busy), 0);
        check("T4 err holds", int'(err), 2);
        idle(2);

        // T5: abort mid-writeback of layer 2 of 3, then restart
        done_count = 0;
        pulse_start(3);
        do_layer(4, 2, 0);
        wait_sig(0, "T5 start_conv seen");
        check("T5 layer 1 idx", int'(layer_idx), 1);
        idle(3); pulse_end();
        wait_sig(1, "T5 wb_req seen");
        idle(1);
        abort = 1'b1; step(); abort = 1'b0;
        check("T5 wb_req cleared", int'(wb_req), 0);
        check("T5 busy cleared", int'(busy), 0);
        check("T5 idx cleared", int'(layer_idx), 0);
        idle(4);
        check("T5 no done", done_count, 0);
        sc_count = 0;
        abort = 1'b1; start = 1'b1; layer_cnt = 3'd2; step();
        abort = 1'b0; start = 1'b0;
        idle(3);
        check("T5 abort beats start", sc_count, 0);
        pulse_start(2);
        do_layer(2, 1, 0);
        do_layer(2, 1, 1);
        wait_sig(2, "T5 done seen");
        idle(1);

        // T6: spurious inputs in every phase of the first layer
        sc_count = 0; done_count = 0;
        pulse_start(4);
        check("T6 launch", int'(start_conv), 1);
        end_conv = 1'b1; start = 1'b1; step(); end_conv = 1'b0; start = 1'b0;
        wb_ack = 1'b1; start = 1'b1; layer_cnt = 3'd1; step(); wb_ack = 1'b0; start = 1'b0;
        check("T6 no early wb_req", int'(wb_req), 0);
        idle(2); pulse_end();
        wait_sig(1, "T6 wb_req seen");
        end_conv = 1'b1; start = 1'b1; step(); end_conv = 1'b0; start = 1'b0;
        check("T6 wb_req held", int'(wb_req), 1);
        pulse_ack();
        for (int i = 1; i < 4; i++) do_layer(2, 1, i);
        wait_sig(2, "T6 done seen");
        idle(2);
        check("T6 start_conv pulses", sc_count, 4);
        check("T6 done pulses", done_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
